fft_frame_sequencer: RTL and testbench

- Streaming front/back-end controller for the 8-point FFT core.
- Collects serial time samples into an 8-sample frame and drives the core's parallel input.
- Pulses the core's ENABLE, waits for FFT_FINISH and captures the 8 complex bins.
- Streams the bins out serially in natural order (bin 0..7) over a valid/ready interface.

---
 rtl/fft_frame_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_fft_frame_sequencer.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_frame_sequencer.sv
// Serial 8-sample collector -> FFT core start/wait -> serial bin drain; FFT_SEQ_OVERLAP_EN adds a ping-pong input bank.
// fft_enable 1 cycle after the 8th sample, first bin 1 cycle after fft_finish; bins hold under !m_ready, s_ready drops with no free bank.
module fft_frame_sequencer #(
  parameter int N_PTS   = 8,
  parameter int DATA_W  = 12,
  parameter int TIMEOUT = 32
) (
  input  logic                    CLK,
  input  logic                    nRESET,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [DATA_W-1:0]       s_data,
  output logic                    fft_enable,
  output logic [N_PTS*DATA_W-1:0] fft_time,
  input  logic                    fft_finish,
  input  logic [N_PTS*DATA_W-1:0] fft_re,
  input  logic [N_PTS*DATA_W-1:0] fft_im,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [DATA_W-1:0]       m_re,
  output logic [DATA_W-1:0]       m_im,
  output logic [2:0]              m_index,
  output logic                    m_last,
  output logic                    busy,
  output logic                    timeout_err
);

  localparam int CNT_W  = $clog2(N_PTS) + 1;
  localparam int WCNT_W = $clog2(TIMEOUT + 1);
`ifdef FFT_SEQ_OVERLAP_EN
  localparam int NBANK = 2;
`else
  localparam int NBANK = 1;
`endif

  typedef enum logic [1:0] {S_COLLECT, S_START, S_WAIT, S_DRAIN} state_t;

  state_t                    state_q, state_d;
  logic [CNT_W-1:0]          count_q, count_d, cnt_inc;
  logic [WCNT_W-1:0]         wait_q, wait_d;
  logic [2:0]                j_q, j_d;
  logic                      tmo_q, tmo_d;
  logic [N_PTS*DATA_W-1:0]   re_q, re_d, im_q, im_d;
  logic [N_PTS*DATA_W-1:0]   bank_q [NBANK];
  logic [N_PTS*DATA_W-1:0]   bank_d [NBANK];
  logic                      fill_sel, xform_sel;
  logic                      s_hs, m_hs;

`ifdef FFT_SEQ_OVERLAP_EN
  logic fill_sel_q, fill_sel_d, xform_sel_q, xform_sel_d;
  assign fill_sel  = fill_sel_q;
  assign xform_sel = xform_sel_q;
  // The idle bank keeps filling while the other is transformed; stall only when it is full.
  assign s_ready   = (state_q == S_COLLECT) || (count_q != CNT_W'(N_PTS));
`else
  assign fill_sel  = 1'b0;
  assign xform_sel = 1'b0;
  assign s_ready   = (state_q == S_COLLECT);
`endif

  assign s_hs        = s_valid && s_ready;
  assign m_valid     = (state_q == S_DRAIN);
  assign m_hs        = m_valid && m_ready;
  assign fft_enable  = (state_q == S_START);
  assign m_re        = re_q[int'(j_q)*DATA_W +: DATA_W];
  assign m_im        = im_q[int'(j_q)*DATA_W +: DATA_W];
  assign m_index     = j_q;
  assign m_last      = m_valid && (j_q == 3'(N_PTS - 1));
  assign busy        = !((state_q == S_COLLECT) && (count_q == '0));
  assign timeout_err = tmo_q;
  assign cnt_inc     = count_q + CNT_W'(s_hs);

  always_comb begin
    fft_time = '0;
    for (int b = 0; b < NBANK; b++)
      if (b == int'(xform_sel)) fft_time = bank_q[b];
  end

  always_comb begin
    state_d = state_q;
    count_d = cnt_inc;
    wait_d  = wait_q;
    j_d     = j_q;
    tmo_d   = tmo_q;
    re_d    = re_q;
    im_d    = im_q;
    bank_d  = bank_q;
`ifdef FFT_SEQ_OVERLAP_EN
    fill_sel_d  = fill_sel_q;
    xform_sel_d = xform_sel_q;
`endif
    for (int b = 0; b < NBANK; b++)
      for (int k = 0; k < N_PTS; k++)
        if (s_hs && b == int'(fill_sel) && k == int'(count_q))
          bank_d[b][k*DATA_W +: DATA_W] = s_data;

    case (state_q)
      S_COLLECT: begin
        if (cnt_inc == CNT_W'(N_PTS)) begin
          state_d = S_START;
          count_d = '0;
        end
      end
      S_START: begin
        wait_d  = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        wait_d = wait_q + WCNT_W'(1);
        // A finish arriving on the last allowed cycle still wins over the timeout.
        if (fft_finish) begin
          re_d    = fft_re;
          im_d    = fft_im;
          state_d = S_DRAIN;
        end else if (wait_q == WCNT_W'(TIMEOUT - 1)) begin
          tmo_d   = 1'b1;
          count_d = '0;
          state_d = S_COLLECT;
        end
      end
      S_DRAIN: begin
        if (m_hs) begin
          j_d = j_q + 3'd1;
          if (j_q == 3'(N_PTS - 1)) begin
            j_d = '0;
            if (cnt_inc == CNT_W'(N_PTS)) begin
              count_d = '0;
              state_d = S_START;
            end else begin
              state_d = S_COLLECT;
            end
          end
        end
      end
      default: state_d = S_COLLECT;
    endcase

`ifdef FFT_SEQ_OVERLAP_EN
    if (state_q != S_START && state_d == S_START) begin
      xform_sel_d = fill_sel_q;
      fill_sel_d  = ~fill_sel_q;
    end
`endif
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      state_q <= S_COLLECT;
      count_q <= '0;
      wait_q  <= '0;
      j_q     <= '0;
      tmo_q   <= 1'b0;
      re_q    <= '0;
      im_q    <= '0;
      bank_q  <= '{default: '0};
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      wait_q  <= wait_d;
      j_q     <= j_d;
      tmo_q   <= tmo_d;
      re_q    <= re_d;
      im_q    <= im_d;
      bank_q  <= bank_d;
    end
  end

`ifdef FFT_SEQ_OVERLAP_EN
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      fill_sel_q  <= 1'b0;
      xform_sel_q <= 1'b0;
    end else begin
      fill_sel_q  <= fill_sel_d;
      xform_sel_q <= xform_sel_d;
    end
  end
`endif

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Bench for fft_frame_sequencer: a core model answers fft_enable and a scoreboard queue of expected bins is checked on every output handshake.
module tb_fft_frame_sequencer;
  localparam int N   = 8;
  localparam int W   = 12;
  localparam int TMO = 32;

  typedef logic [W+W+3:0] beat_t;

  logic           CLK = 1'b0;
  logic           nRESET = 1'b0;
  logic           s_valid = 1'b0, s_ready;
  logic [W-1:0]   s_data = '0;
  logic           fft_enable;
  logic [N*W-1:0] fft_time;
  logic           fft_finish = 1'b0;
  logic [N*W-1:0] fft_re = '0, fft_im = '0;
  logic           m_valid, m_ready = 1'b0;
  logic [W-1:0]   m_re, m_im;
  logic [2:0]     m_index;
  logic           m_last, busy, timeout_err;

  beat_t exp_q[$];
  int    checks = 0;
  int    failures = 0;

  always #5 CLK = ~CLK;

  fft_frame_sequencer #(.N_PTS(N), .DATA_W(W), .TIMEOUT(TMO)) dut (
    .CLK(CLK), .nRESET(nRESET),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .fft_enable(fft_enable), .fft_time(fft_time), .fft_finish(fft_finish),
    .fft_re(fft_re), .fft_im(fft_im),
    .m_valid(m_valid), .m_ready(m_ready), .m_re(m_re), .m_im(m_im),
    .m_index(m_index), .m_last(m_last), .busy(busy), .timeout_err(timeout_err)
  );

  task automatic push_sample(input logic [W-1:0] d);
    int n = 0;
    s_valid = 1'b1;
    s_data  = d;
    while (s_ready !== 1'b1 && n < 200) begin
      @(negedge CLK);
      n++;
    end
    checks++;
    if (n >= 200) begin
      failures++;
      $display("FAIL sample_accept got=stalled want=accepted data=%h", d);
    end
    @(negedge CLK);
    s_valid = 1'b0;
    s_data  = W'($urandom);
  endtask

  task automatic send_frame(input logic [W-1:0] smp [N]);
    logic [N*W-1:0] f;
    for (int k = 0; k < N; k++) begin
      push_sample(smp[k]);
      f[k*W +: W] = smp[k];
    end
    checks++;
    if (fft_enable !== 1'b1) begin
      failures++;
      $display("FAIL enable_latency got=%b want=1", fft_enable);
    end
    checks++;
    if (fft_time !== f) begin
      failures++;
      $display("FAIL fft_time got=%h want=%h", fft_time, f);
    end
  endtask

  task automatic core_respond(input int dly, input logic [N*W-1:0] re, input logic [N*W-1:0] im);
    for (int k = 0; k < N; k++)
      exp_q.push_back({re[k*W +: W], im[k*W +: W], 3'(k), (k == N - 1)});
    repeat (dly) @(negedge CLK);
    fft_finish = 1'b1;
    fft_re = re;
    fft_im = im;
    @(negedge CLK);
    fft_finish = 1'b0;
    fft_re = ~re;
    fft_im = ~im;
    checks++;
    if (m_valid !== 1'b1) begin
      failures++;
      $display("FAIL first_bin_latency got=%b want=1", m_valid);
    end
  endtask

  task automatic drain(input bit bp, input int nbeats);
    int n = 0;
    int got = 0;
    beat_t e, h;
    while (exp_q.size() > 0 && got < nbeats && n < 400) begin
      m_ready = bp ? ((n % 4 == 0) || (n % 4 == 3)) : 1'b1;
      if (m_valid === 1'b1 && m_ready) begin
        e = exp_q.pop_front();
        got++;
        checks++;
        if ({m_re, m_im, m_index, m_last} !== e) begin
          failures++;
          $display("FAIL bin got=%h want=%h", {m_re, m_im, m_index, m_last}, e);
        end
        @(negedge CLK);
      end else if (m_valid === 1'b1) begin
        h = {m_re, m_im, m_index, m_last};
        @(negedge CLK);
        checks++;
        if (m_valid !== 1'b1 || {m_re, m_im, m_index, m_last} !== h) begin
          failures++;
          $display("FAIL hold got=%b/%h want=1/%h", m_valid, {m_re, m_im, m_index, m_last}, h);
        end
      end else begin
        checks++;
        failures++;
        $display("FAIL m_valid_gap got=%b want=1", m_valid);
        @(negedge CLK);
      end
      n++;
    end
    m_ready = 1'b0;
    checks++;
    if (got < nbeats) begin
      failures++;
      $display("FAIL drain_count got=%0d want=%0d", got, nbeats);
    end
  endtask

  task automatic check_idle(input string tag);
    checks++;
    if ({m_valid, s_ready, busy} !== 3'b010) begin
      failures++;
      $display("FAIL %s_idle got=%b want=010", tag, {m_valid, s_ready, busy});
    end
  endtask

  task automatic test_reset();
    nRESET = 1'b0;
    repeat (2) @(negedge CLK);
    checks++;
    if ({s_ready, fft_enable, m_valid, m_last, busy, timeout_err} !== 6'b100000) begin
      failures++;
      $display("FAIL reset_ctl got=%b want=100000", {s_ready, fft_enable, m_valid, m_last, busy, timeout_err});
    end
    checks++;
    if (fft_time !== '0 || {m_re, m_im, m_index} !== '0) begin
      failures++;
      $display("FAIL reset_data got=%h/%h want=0/0", fft_time, {m_re, m_im, m_index});
    end
    nRESET = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_impulse();
    logic [W-1:0] smp [N];
    logic [N*W-1:0] re;
    for (int k = 0; k < N; k++) begin
      smp[k] = (k == 0) ? 12'h080 : 12'h000;
      re[k*W +: W] = 12'h010;
    end
    send_frame(smp);
    @(negedge CLK);
    checks++;
    if ({fft_enable, busy} !== 2'b01) begin
      failures++;
      $display("FAIL enable_single_pulse got=%b want=01", {fft_enable, busy});
    end
    core_respond(2, re, '0);
    drain(1'b0, N);
    check_idle("impulse");
  endtask

  task automatic test_finish_at_timeout();
    logic [W-1:0] smp [N];
    logic [N*W-1:0] re, im;
    for (int k = 0; k < N; k++) begin
      smp[k] = W'($urandom);
      re[k*W +: W] = W'($urandom);
      im[k*W +: W] = W'($urandom);
    end
    send_frame(smp);
    core_respond(TMO, re, im);
    drain(1'b0, N);
    checks++;
    if (timeout_err !== 1'b0) begin
      failures++;
      $display("FAIL finish_beats_timeout got=%b want=0", timeout_err);
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] smp [N];
    logic [N*W-1:0] re, im;
    for (int k = 0; k < N; k++) begin
      smp[k] = W'(k * 12'h111);
      re[k*W +: W] = W'(12'h100 + k);
      im[k*W +: W] = W'(12'hF00 - k);
    end
    send_frame(smp);
`ifndef FFT_SEQ_OVERLAP_EN
    @(negedge CLK);
    checks++;
    if (s_ready !== 1'b0) begin
      failures++;
      $display("FAIL s_ready_in_wait got=%b want=0", s_ready);
    end
`endif
    core_respond(3, re, im);
    drain(1'b1, N);
    check_idle("backpressure");
  endtask

  task automatic test_timeout();
    logic [W-1:0] smp [N];
    int n = 0;
    bit seen_mv = 1'b0;
    for (int k = 0; k < N; k++) smp[k] = W'($urandom);
    send_frame(smp);
    while (timeout_err !== 1'b1 && n < 60) begin
      @(negedge CLK);
      n++;
      if (m_valid === 1'b1) seen_mv = 1'b1;
    end
    checks++;
    if (n != TMO + 1) begin
      failures++;
      $display("FAIL timeout_cycles got=%0d want=%0d", n, TMO + 1);
    end
    checks++;
    if (seen_mv) begin
      failures++;
      $display("FAIL timeout_m_valid got=1 want=0");
    end
    check_idle("timeout");
  endtask

  task automatic test_stray_finish();
    logic [W-1:0] smp [N];
    logic [N*W-1:0] re, im;
    for (int k = 0; k < N; k++) begin
      smp[k] = W'(12'h0A0 + k);
      re[k*W +: W] = W'($urandom);
      im[k*W +: W] = W'($urandom);
    end
    for (int k = 0; k < 3; k++) push_sample(smp[k]);
    fft_finish = 1'b1;
    fft_re = re;
    fft_im = im;
    @(negedge CLK);
    fft_finish = 1'b0;
    repeat (2) begin
      checks++;
      if ({m_valid, busy, s_ready} !== 3'b011) begin
        failures++;
        $display("FAIL stray_finish got=%b want=011", {m_valid, busy, s_ready});
      end
      @(negedge CLK);
    end
    for (int k = 3; k < N - 1; k++) push_sample(smp[k]);
    checks++;
    if (fft_enable !== 1'b0) begin
      failures++;
      $display("FAIL stray_count_early got=%b want=0", fft_enable);
    end
    push_sample(smp[N-1]);
    checks++;
    if (fft_enable !== 1'b1 || fft_time !== {smp[7], smp[6], smp[5], smp[4], smp[3], smp[2], smp[1], smp[0]}) begin
      failures++;
      $display("FAIL stray_frame got=%b/%h want=1/frame", fft_enable, fft_time);
    end
    core_respond(1, re, im);
    drain(1'b0, N);
    checks++;
    if (timeout_err !== 1'b1) begin
      failures++;
      $display("FAIL timeout_sticky got=%b want=1", timeout_err);
    end
  endtask

  task automatic test_reset_mid_drain();
    logic [W-1:0] smp [N];
    logic [N*W-1:0] re, im;
    for (int k = 0; k < N; k++) begin
      smp[k] = W'($urandom);
      re[k*W +: W] = W'($urandom);
      im[k*W +: W] = W'($urandom);
    end
    send_frame(smp);
    core_respond(2, re, im);
    drain(1'b0, 4);
    checks++;
    if ({m_valid, m_index} !== 4'b1100) begin
      failures++;
      $display("FAIL at_bin4 got=%b want=1100", {m_valid, m_index});
    end
    nRESET = 1'b0;
    #1;
    checks++;
    if ({m_valid, s_ready, busy, timeout_err} !== 4'b0100) begin
      failures++;
      $display("FAIL async_reset got=%b want=0100", {m_valid, s_ready, busy, timeout_err});
    end
    exp_q.delete();
    @(negedge CLK);
    nRESET = 1'b1;
    @(negedge CLK);
    for (int k = 0; k < N; k++) smp[k] = W'(12'h7F0 - k);
    send_frame(smp);
    core_respond(2, im, re);
    drain(1'b0, N);
    check_idle("after_reset");
  endtask

`ifdef FFT_SEQ_OVERLAP_EN
  task automatic test_overlap();
    logic [W-1:0] smp [2*N];
    logic [N*W-1:0] fa, fb, re, im;
    for (int k = 0; k < 2 * N; k++) smp[k] = W'(12'h300 + k);
    for (int k = 0; k < N; k++) begin
      fa[k*W +: W] = smp[k];
      fb[k*W +: W] = smp[N+k];
      re[k*W +: W] = W'($urandom);
      im[k*W +: W] = W'($urandom);
    end
    fork
      for (int k = 0; k < 2 * N; k++) push_sample(smp[k]);
      begin
        int n = 0;
        while (fft_enable !== 1'b1 && n < 100) begin
          @(negedge CLK);
          n++;
        end
        checks++;
        if (fft_time !== fa || fft_enable !== 1'b1) begin
          failures++;
          $display("FAIL overlap_first got=%b/%h want=1/%h", fft_enable, fft_time, fa);
        end
        core_respond(3, re, im);
        drain(1'b0, N);
        checks++;
        if (fft_enable !== 1'b1 || fft_time !== fb) begin
          failures++;
          $display("FAIL overlap_second got=%b/%h want=1/%h", fft_enable, fft_time, fb);
        end
        core_respond(2, im, re);
        drain(1'b0, N);
      end
    join
    check_idle("overlap");
  endtask
`endif

  initial begin
    test_reset();
    test_impulse();
    test_finish_at_timeout();
    test_backpressure();
    test_timeout();
    test_stray_finish();
    test_reset_mid_drain();
`ifdef FFT_SEQ_OVERLAP_EN
    test_overlap();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
